chroni_vram_arbiter: RTL

CHRONI_VRAM_ARBITER -- requirements
Module: chroni_vram_arbiter

---
 rtl/chroni_vram_pkg.sv | 21 ++
 rtl/chroni_vram_rd_pipe.sv | 37 +++
 rtl/chroni_vram_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/chroni_vram_pkg.sv
// Shared widths, requester tags and grant-bit indices for the Chroni VRAM arbiter.
// The DMA requester is only arbitrated when CHRONI_VRAM_DMA_EN is defined.
package chroni_vram_pkg;

  localparam int VRAM_AW = 17;
  localparam int VRAM_DW = 8;

  localparam logic [1:0] TAG_DISP = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [1:0] TAG_DMA  = 2'd2;

  localparam int GNT_DISP = 0;
  localparam int GNT_CPU  = 1;
  localparam int GNT_DMA  = 2;

  typedef struct packed {
    logic       valid;
    logic [1:0] tag;
  } rd_tag_t;

endpackage

// File: rtl/chroni_vram_rd_pipe.sv
// In-order {valid, tag} shift pipeline tracking reads in flight to VRAM.
// No backpressure: one entry enters and one leaves every cycle.
module chroni_vram_rd_pipe
  import chroni_vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_tag,
  output logic       out_valid,
  output logic [1:0] out_tag
);

  rd_tag_t pipe_q [DEPTH];
  rd_tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = {in_valid, in_tag};
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_valid = pipe_q[DEPTH-1].valid;
  assign out_tag   = pipe_q[DEPTH-1].tag;

endmodule

// File: rtl/chroni_vram_arbiter.sv
// Single-port VRAM arbiter: display > cpu > dma with starvation override.
// DMA arbitration is built only when CHRONI_VRAM_DMA_EN is defined.
module chroni_vram_arbiter
  import chroni_vram_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int RD_LATENCY   = 2
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic                 disp_req,
  input  logic [VRAM_AW-1:0]   disp_addr,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [VRAM_AW-1:0]   cpu_addr,
  input  logic [VRAM_DW-1:0]   cpu_wr_data,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [VRAM_AW-1:0]   dma_addr,
  input  logic [VRAM_DW-1:0]   dma_wr_data,
  output logic [2:0]           gnt,
  output logic                 rd_valid,
  output logic [1:0]           rd_tag,
  output logic [VRAM_DW-1:0]   rd_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [VRAM_AW-1:0]   mem_addr,
  output logic [VRAM_DW-1:0]   mem_wr_data,
  input  logic [VRAM_DW-1:0]   mem_rd_data
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] cpu_age_q, cpu_age_d;
  logic             cpu_sat, dma_sat, dma_req_i;
  logic             cpu_hi, dma_hi;
  logic [2:0]       gnt_c;

  assign cpu_sat = (cpu_age_q == AGE_MAX);

`ifdef CHRONI_VRAM_DMA_EN
  logic [AGE_W-1:0] dma_age_q, dma_age_d;

  assign dma_req_i = dma_req;
  assign dma_sat   = (dma_age_q == AGE_MAX);

  always_comb begin
    dma_age_d = '0;
    if (dma_req && !gnt_c[GNT_DMA]) begin
      dma_age_d = dma_sat ? dma_age_q : dma_age_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_age_q <= '0;
    end else begin
      dma_age_q <= dma_age_d;
    end
  end
`else
  logic unused_dma_req;

  assign unused_dma_req = dma_req;
  assign dma_req_i      = 1'b0;
  assign dma_sat        = 1'b0;
`endif

  // Starved requesters pre-empt display; a starved cpu beats a starved dma.
  assign cpu_hi = cpu_req & cpu_sat;
  assign dma_hi = dma_req_i & dma_sat;

  always_comb begin
    gnt_c = '0;
    gnt_c[GNT_CPU]  = cpu_hi | (cpu_req & ~dma_hi & ~disp_req);
    gnt_c[GNT_DMA]  = ~gnt_c[GNT_CPU] &
                      (dma_hi | (dma_req_i & ~disp_req));
    gnt_c[GNT_DISP] = disp_req & ~cpu_hi & ~dma_hi;
    gnt_c = gnt_c & {3{reset_n}};
  end

  assign gnt = gnt_c;

  always_comb begin
    cpu_age_d = '0;
    if (cpu_req && !gnt_c[GNT_CPU]) begin
      cpu_age_d = cpu_sat ? cpu_age_q : cpu_age_q + 1'b1;
    end
  end

  logic               xfer, sel_we;
  logic [VRAM_AW-1:0] sel_addr;
  logic [VRAM_DW-1:0] sel_wdata;
  logic [1:0]         sel_tag;

  assign xfer = |gnt_c;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = disp_addr;
    sel_wdata = '0;
    sel_tag   = TAG_DISP;
    unique case (1'b1)
      gnt_c[GNT_CPU]: begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wr_data;
        sel_tag   = TAG_CPU;
      end
      gnt_c[GNT_DMA]: begin
        sel_we    = dma_we;
        sel_addr  = dma_addr;
        sel_wdata = dma_wr_data;
        sel_tag   = TAG_DMA;
      end
      default: ;
    endcase
  end

  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [VRAM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [VRAM_DW-1:0] mem_wd_q, mem_wd_d;
  logic               pipe_valid;
  logic [1:0]         pipe_tag;
  logic               rd_valid_q, rd_valid_d;
  logic [1:0]         rd_tag_q, rd_tag_d;
  logic [VRAM_DW-1:0] rd_data_q, rd_data_d;

  always_comb begin
    mem_en_d   = xfer;
    mem_we_d   = xfer & sel_we;
    mem_addr_d = xfer ? sel_addr : mem_addr_q;
    mem_wd_d   = xfer ? sel_wdata : mem_wd_q;
    rd_valid_d = pipe_valid;
    rd_tag_d   = pipe_valid ? pipe_tag : rd_tag_q;
    rd_data_d  = pipe_valid ? mem_rd_data : rd_data_q;
  end

  chroni_vram_rd_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rd_pipe (
    .clk      (sys_clk),
    .rst_n    (reset_n),
    .in_valid (xfer & ~sel_we),
    .in_tag   (sel_tag),
    .out_valid(pipe_valid),
    .out_tag  (pipe_tag)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_age_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      cpu_age_q  <= cpu_age_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wd_q;
  assign rd_valid    = rd_valid_q;
  assign rd_tag      = rd_tag_q;
  assign rd_data     = rd_data_q;

endmodule
